// File: rtl/pkt_gen_axis.sv
// pkt_gen_axis: AXI4-Stream test-packet generator with programmable length, gap, count, pattern and TUSER header.
//   S_AXI_ACLK/S_AXI_ARESETN : clock, async active-low reset
//   cfg_*                    : run configuration from the register block (latched per packet)
//   rst_cntrs                : synchronous clear of tx_pkt_count/tx_word_count
//   M_AXIS_*                 : registered AXI4-Stream master
//   tx_pkt_count/word_count  : statistics; busy/done : run status
module pkt_gen_axis #(
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_LEN_WIDTH          = 16,
  parameter int C_CNT_WIDTH          = 32
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic                              cfg_enable,
  input  logic [C_LEN_WIDTH-1:0]            cfg_pkt_len,
  input  logic [C_CNT_WIDTH-1:0]            cfg_gap,
  input  logic [C_CNT_WIDTH-1:0]            cfg_num_pkts,
  input  logic [7:0]                        cfg_src_port,
  input  logic [7:0]                        cfg_dst_port,
  input  logic                              cfg_mode,
  input  logic [63:0]                       cfg_pattern,
  input  logic                              rst_cntrs,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  output logic [C_CNT_WIDTH-1:0]            tx_pkt_count,
  output logic [C_CNT_WIDTH-1:0]            tx_word_count,
  output logic                              busy,
  output logic                              done
);
  localparam int DW = C_M_AXIS_DATA_WIDTH;
  localparam int UW = C_M_AXIS_TUSER_WIDTH;
  localparam int B  = DW / 8;
  localparam int LW = C_LEN_WIDTH;
  localparam int CW = C_CNT_WIDTH;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t state, state_nx;
  logic [LW-1:0] len_q, rem_q, eff_len, nxt_rem;
  logic [CW-1:0] gap_q, gcnt_q, run_q, run_inc;
  logic [63:0] pat_q, eff_pat;
  logic [31:0] idx_q, seq_q, nxt_idx, nxt_seq;
  logic [DW-1:0] nxt_data;
  logic [B-1:0] nxt_strb;
  logic [UW-1:0] nxt_user;
  logic mode_q, eff_mode, hs, last, run_end, start, step;
  // rem_q holds the bytes still to send, counting the beat currently presented
  assign hs      = M_AXIS_TVALID & M_AXIS_TREADY;
  assign last    = rem_q <= LW'(B);
  assign run_inc = run_q + CW'(1);
  assign run_end = (cfg_num_pkts != '0) && (run_inc == cfg_num_pkts);
  // start: present a header beat using live cfg; step: present the next beat of the current packet
  always_comb begin
    state_nx = state;
    start = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: if (cfg_enable) begin start = 1'b1; state_nx = SEND; end
      SEND: if (hs) begin
        if (!last) step = 1'b1;
        else if (run_end) state_nx = DONE;
        else if (!cfg_enable) state_nx = IDLE;
        else if (gap_q == '0) start = 1'b1;
        else state_nx = GAP;
      end
      GAP: if (!cfg_enable) state_nx = IDLE;
           else if (gcnt_q == '0) begin start = 1'b1; state_nx = SEND; end
      default: if (!cfg_enable) state_nx = IDLE;
    endcase
  end
  always_comb begin
    eff_len = start ? ((cfg_pkt_len == '0) ? LW'(1) : cfg_pkt_len) : len_q;
    eff_mode = start ? cfg_mode : mode_q;
    eff_pat = start ? cfg_pattern : pat_q;
    nxt_rem = start ? eff_len : rem_q - LW'(B);
    nxt_idx = start ? 32'd0 : idx_q + 32'd1;
    nxt_seq = start ? ((state == IDLE) ? 32'd0 : seq_q + 32'd1) : seq_q;
    nxt_user = start ? UW'({cfg_dst_port, cfg_src_port, 16'(eff_len)}) : '0;
    for (int i = 0; i < B; i++) nxt_strb[i] = LW'(i) < nxt_rem;
    for (int i = 0; i < DW / 64; i++) nxt_data[i*64 +: 64] = eff_mode ? {nxt_seq, nxt_idx} : eff_pat;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state <= IDLE;
      M_AXIS_TDATA <= '0;
      M_AXIS_TSTRB <= '0;
      M_AXIS_TUSER <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST <= 1'b0;
      len_q <= '0;
      rem_q <= '0;
      gap_q <= '0;
      gcnt_q <= '0;
      run_q <= '0;
      pat_q <= '0;
      mode_q <= 1'b0;
      idx_q <= '0;
      seq_q <= '0;
      tx_pkt_count <= '0;
      tx_word_count <= '0;
    end else begin
      state <= state_nx;
      if (start || step) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA <= nxt_data;
        M_AXIS_TSTRB <= nxt_strb;
        M_AXIS_TUSER <= nxt_user;
        M_AXIS_TLAST <= (nxt_rem <= LW'(B));
        rem_q <= nxt_rem;
        idx_q <= nxt_idx;
        seq_q <= nxt_seq;
      end else if (hs) M_AXIS_TVALID <= 1'b0;
      if (start) begin
        len_q <= eff_len;
        gap_q <= cfg_gap;
        mode_q <= cfg_mode;
        pat_q <= cfg_pattern;
      end
      run_q <= (state == IDLE) ? '0 : (hs && last) ? run_inc : run_q;
      // preloaded outside GAP so the gap lasts exactly gap_q cycles
      gcnt_q <= (state == GAP) ? gcnt_q - CW'(1) : gap_q - CW'(1);
      tx_word_count <= rst_cntrs ? '0 : tx_word_count + CW'(hs);
      tx_pkt_count <= rst_cntrs ? '0 : tx_pkt_count + CW'(hs && last);
    end
  end
  assign busy = (state == SEND) || (state == GAP);
  assign done = state == DONE;
endmodule

// File: tb/tb_pkt_gen_axis.sv
// tb_pkt_gen_axis: self-checking bench for pkt_gen_axis (64-bit data, 128-bit TUSER).
module tb_pkt_gen_axis;
  typedef struct {
    logic [63:0]  d;
    logic [7:0]   s;
    logic [127:0] u;
    logic         l;
  } beat_t;
  logic clk = 0, rst_n = 0, en = 0, mode = 0, rst_c = 0, tready = 1, rnd = 0;
  logic [15:0] len = 0;
  logic [31:0] gap = 0, num = 0;
  logic [7:0] src = 0, dst = 0;
  logic [63:0] pat = 0;
  logic [63:0] tdata;
  logic [7:0] tstrb;
  logic [127:0] tuser;
  logic tvalid, tlast, busy, done;
  logic [31:0] pkt_cnt, word_cnt;
  beat_t q[$];
  beat_t e;
  logic [63:0] log_d[256];
  logic [7:0] log_s[256];
  logic [127:0] log_u[256];
  logic log_l[256];
  int log_c[256];
  int nlog = 0, cyc = 0, done_cyc = 0, n_chk = 0, n_pass = 0, exp_w = 0, exp_p = 0, base = 0;
  logic stall = 0, prev_done = 0, hs, lastb;
  logic [63:0] h_d;
  logic [7:0] h_s;
  logic [127:0] h_u;
  logic h_l;

  pkt_gen_axis dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .cfg_enable(en), .cfg_pkt_len(len),
    .cfg_gap(gap), .cfg_num_pkts(num), .cfg_src_port(src), .cfg_dst_port(dst),
    .cfg_mode(mode), .cfg_pattern(pat), .rst_cntrs(rst_c),
    .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb), .M_AXIS_TUSER(tuser),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast),
    .tx_pkt_count(pkt_cnt), .tx_word_count(word_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_chk=%0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Expected beats of one packet, derived from length arithmetic
  task automatic push_pkt(input int l_in, input int seq, input logic md, input logic [63:0] p,
                          input logic [7:0] s, input logic [7:0] d);
    int l = (l_in == 0) ? 1 : l_in;
    int n = (l + 7) / 8;
    for (int b = 0; b < n; b++) begin
      beat_t x;
      x.d = md ? {seq[31:0], b[31:0]} : p;
      x.s = (b == n - 1 && l % 8 != 0) ? 8'((1 << (l % 8)) - 1) : 8'hFF;
      x.u = (b == 0) ? {96'd0, d, s, l[15:0]} : 128'd0;
      x.l = b == n - 1;
      q.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin tick(); k++; end
    chk("done_reached", done, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k = 0;
    while (nlog < target && k < budget) begin tick(); k++; end
    chk("beats_reached", nlog >= target, 1);
  endtask

  task automatic idle();
    en = 0;
    repeat (3) tick();
  endtask

  // Scoreboard: one pass per cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_w = 0;
      exp_p = 0;
      stall = 0;
      prev_done = 0;
    end else begin
      chk("word_count", word_cnt, exp_w);
      chk("pkt_count", pkt_cnt, exp_p);
      if (stall) begin
        chk("stall_valid", tvalid, 1);
        chk("stall_data", tdata, h_d);
        chk("stall_strb", tstrb, h_s);
        chk("stall_user", tuser, h_u);
        chk("stall_last", tlast, h_l);
      end
      hs = tvalid && tready;
      lastb = 0;
      if (hs) begin
        chk("beat_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          lastb = e.l;
          chk("tdata", tdata, e.d);
          chk("tstrb", tstrb, e.s);
          chk("tuser", tuser, e.u);
          chk("tlast", tlast, e.l);
        end
        if (nlog < 256) begin
          log_d[nlog] = tdata;
          log_s[nlog] = tstrb;
          log_u[nlog] = tuser;
          log_l[nlog] = tlast;
          log_c[nlog] = cyc;
        end
        nlog++;
      end
      stall = tvalid && !tready;
      h_d = tdata;
      h_s = tstrb;
      h_u = tuser;
      h_l = tlast;
      if (rst_c) begin exp_w = 0; exp_p = 0; end
      else if (hs) begin exp_w++; exp_p += int'(lastb); end
      if (done && !prev_done) done_cyc = cyc;
      prev_done = done;
    end
  end

  initial begin
    len = 64; gap = 0; num = 2; src = 8'h80; dst = 8'h04; mode = 0; pat = 64'hAAAA_AAAA_AAAA_AAAA;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", word_cnt, 0);
    chk("rst_pkts", pkt_cnt, 0);
    rst_n = 1;
    tick();
    // two 8-beat packets, back-to-back
    base = nlog;
    push_pkt(64, 0, 0, pat, src, dst);
    push_pkt(64, 1, 0, pat, src, dst);
    en = 1;
    wait_done(100);
    chk("t1_beats", nlog - base, 16);
    chk("t1_contig", log_c[base+15] - log_c[base], 15);
    chk("t1_user0", log_u[base], 128'h04800040);
    chk("t1_user8", log_u[base+8], 128'h04800040);
    chk("t1_data0", log_d[base], 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t1_last7", log_l[base+7], 1);
    chk("t1_last15", log_l[base+15], 1);
    chk("t1_done_next", done_cyc - log_c[base+15], 1);
    chk("t1_pkts", pkt_cnt, 2);
    chk("t1_words", word_cnt, 16);
    chk("t1_qempty", q.size(), 0);
    idle();
    // 13-byte sequence packet
    len = 13; mode = 1; num = 1;
    base = nlog;
    push_pkt(13, 0, 1, pat, src, dst);
    en = 1;
    wait_done(50);
    chk("t2_beats", nlog - base, 2);
    chk("t2_strb0", log_s[base], 8'hFF);
    chk("t2_strb1", log_s[base+1], 8'h1F);
    chk("t2_data0", log_d[base], 64'h0);
    chk("t2_data1", log_d[base+1], 64'h1);
    chk("t2_user0", log_u[base], 128'h0480000D);
    idle();
    // inter-packet gap of 3
    len = 16; gap = 3; num = 3;
    base = nlog;
    for (int i = 0; i < 3; i++) push_pkt(16, i, 1, pat, src, dst);
    en = 1;
    wait_done(100);
    chk("t3_beats", nlog - base, 6);
    chk("t3_gap1", log_c[base+2] - log_c[base+1] - 1, 3);
    chk("t3_gap2", log_c[base+4] - log_c[base+3] - 1, 3);
    chk("t3_nogap_end", done_cyc - log_c[base+5], 1);
    chk("t3_seq2", log_d[base+5], {32'd2, 32'd1});
    idle();
    // random back-pressure
    len = 20; gap = 1; num = 4;
    base = nlog;
    for (int i = 0; i < 4; i++) push_pkt(20, i, 1, pat, src, dst);
    rnd = 1;
    en = 1;
    wait_done(600);
    rnd = 0;
    tready = 1;
    chk("t4_beats", nlog - base, 12);
    chk("t4_strb_last", log_s[base+11], 8'h0F);
    chk("t4_words", word_cnt, 36);
    chk("t4_qempty", q.size(), 0);
    idle();
    // enable dropped mid-packet, unlimited run
    len = 64; gap = 0; num = 0; mode = 0; pat = 64'h0123_4567_89AB_CDEF;
    base = nlog;
    push_pkt(64, 0, 0, pat, src, dst);
    en = 1;
    wait_beats(base + 2, 50);
    en = 0;
    for (int k = 0; k < 40 && busy; k++) tick();
    repeat (5) tick();
    chk("t5_beats", nlog - base, 8);
    chk("t5_last7", log_l[base+7], 1);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_tvalid", tvalid, 0);
    chk("t5_qempty", q.size(), 0);
    // rst_cntrs coincident with a last-beat handshake
    len = 8; num = 1;
    push_pkt(8, 0, 0, pat, src, dst);
    en = 1;
    tick();
    chk("t7_valid", tvalid, 1);
    chk("t7_last", tlast, 1);
    chk("t7_user", tuser, 128'h04800008);
    chk("t7_words_before", word_cnt, 44);
    rst_c = 1;
    tick();
    rst_c = 0;
    chk("t7_words", word_cnt, 0);
    chk("t7_pkts", pkt_cnt, 0);
    chk("t7_done", done, 1);
    idle();
    // asynchronous reset mid-packet
    len = 64; num = 0;
    base = nlog;
    push_pkt(64, 0, 0, pat, src, dst);
    en = 1;
    wait_beats(base + 3, 50);
    chk("t6_words_before", word_cnt != 0, 1);
    rst_n = 0;
    #1;
    chk("t6_tvalid", tvalid, 0);
    chk("t6_words", word_cnt, 0);
    chk("t6_pkts", pkt_cnt, 0);
    chk("t6_busy", busy, 0);
    en = 0;
    repeat (2) tick();
    rst_n = 1;
    repeat (3) tick();
    chk("t6_idle_valid", tvalid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pkt_gen_axis.md
Name: pkt_gen_axis

Overview:
Parametrised AXI4-Stream test-packet generator; successor to the fixed two-beat transmitter.
- Emits NetFPGA-format packets of programmable length, TUSER metadata, payload pattern, inter-packet gap and packet count.
- Keeps running packet/word counters for the register block.
- Sits between the register (ipif_regs) block, which drives the cfg_* ports, and the output-port datapath.

Parameters:
C_M_AXIS_DATA_WIDTH, 64, stream data width in bits; multiple of 64, 64..256.
C_M_AXIS_TUSER_WIDTH, 128, TUSER width; bits [31:0] carry length/src/dst, rest zero.
C_LEN_WIDTH, 16, width of cfg_pkt_len (bytes).
C_CNT_WIDTH, 32, width of cfg_num_pkts, cfg_gap and the statistics counters.

Ports:
S_AXI_ACLK  in  1  single clock for all logic.
S_AXI_ARESETN  in  1  asynchronous active-low reset.
cfg_enable  in  1  level; 1 = generate packets.
cfg_pkt_len  in  C_LEN_WIDTH  packet length in bytes; 0 is treated as 1.
cfg_gap  in  C_CNT_WIDTH  idle cycles between packets; 0 = back-to-back.
cfg_num_pkts  in  C_CNT_WIDTH  packets per run; 0 = unlimited.
cfg_src_port  in  8  TUSER[23:16] value.
cfg_dst_port  in  8  TUSER[31:24] value.
cfg_mode  in  1  0 = constant pattern, 1 = sequence pattern.
cfg_pattern  in  64  constant payload word, replicated across lanes.
rst_cntrs  in  1  synchronous clear of the statistics counters.
M_AXIS_TDATA  out  C_M_AXIS_DATA_WIDTH  stream data.
M_AXIS_TSTRB  out  C_M_AXIS_DATA_WIDTH/8  byte strobes.
M_AXIS_TUSER  out  C_M_AXIS_TUSER_WIDTH  metadata; first beat only.
M_AXIS_TVALID  out  1  data valid.
M_AXIS_TREADY  in  1  downstream ready.
M_AXIS_TLAST  out  1  last beat of the packet.
tx_pkt_count  out  C_CNT_WIDTH  packets completed.
tx_word_count  out  C_CNT_WIDTH  beats accepted.
busy  out  1  1 when the state is not IDLE or DONE.
done  out  1  1 when the cfg_num_pkts run is complete.

Behaviour:
- Reset: asynchronous, active-low. All outputs, counters and state return to 0 / IDLE immediately, including mid-packet; no partial-packet recovery.
- All stream outputs are registered. Handshake occurs when TVALID & TREADY. While TVALID=1 and TREADY=0, TDATA, TSTRB, TUSER and TLAST hold stable.
- Let B = C_M_AXIS_DATA_WIDTH/8 and L = max(cfg_pkt_len, 1).
  - Beats per packet N = ceil(L/B).
  - Last-beat TSTRB has the low (L mod B) bits set, or all bits if the remainder is 0. All other beats have all bits set.
- cfg_pkt_len, cfg_gap, cfg_mode, cfg_pattern and the ports are latched at each packet start. Changes mid-packet take effect on the next packet.
- First beat: TUSER[15:0] = L, [23:16] = src, [31:24] = dst, upper bits 0. TUSER = 0 on all other beats.
- Data, mode 0: cfg_pattern in every 64-bit lane.
- Data, mode 1: every 64-bit lane = {pkt_seq[31:0], beat_idx[31:0]}.
  - pkt_seq counts packets since leaving IDLE, starting at 0.
  - beat_idx starts at 0 in each packet.
- FSM states: IDLE, SEND, GAP, DONE.
  - IDLE: waits for cfg_enable=1; clears the run counter and pkt_seq; loads the first beat; goes to SEND with TVALID=1 on the next cycle.
  - SEND: advances one beat per handshake. On the last-beat handshake the next state is chosen in this order:
    - run complete -> DONE;
    - cfg_enable=0 -> IDLE;
    - cfg_gap=0 -> SEND, with the next header beat presented the following cycle (TVALID stays 1);
    - otherwise -> GAP.
  - GAP: TVALID=0 for exactly cfg_gap cycles, then SEND. If cfg_enable=0 during GAP -> IDLE.
  - DONE: done=1, TVALID=0; leaves to IDLE only when cfg_enable=0.
- Deasserting cfg_enable mid-packet never truncates the packet; it is completed first.
- tx_word_count increments on every handshake. tx_pkt_count increments on each last-beat handshake.
  - Both counters wrap modulo 2^C_CNT_WIDTH.
  - rst_cntrs has priority over an increment in the same cycle.
  - rst_cntrs does not affect the FSM or the run counter.
- Single-beat packet (N=1): TLAST=1 and TUSER non-zero on the same beat.

Test Plan:
- 64-bit, len=64, src=0x80, dst=0x04, gap=0, num=2, mode 0, pattern=0xAAAA_AAAA_AAAA_AAAA, TREADY=1 -> 16 contiguous beats; TUSER=0x04800040 on beats 0 and 8; TLAST on beats 7 and 15; done=1; tx_pkt_count=2; tx_word_count=16.
- len=13, mode 1, num=1 -> 2 beats; TSTRB 0xFF then 0x1F; TDATA 0x0000_0000_0000_0000 then 0x0000_0000_0000_0001.
- gap=3, num=3, TREADY=1 -> exactly 3 TVALID=0 cycles between each TLAST handshake and the next header beat; no gap after the third packet.
- TREADY toggled pseudo-randomly -> outputs stable while stalled; no beat lost or duplicated (checked by scoreboard); tx_word_count matches handshakes.
- cfg_enable dropped on beat 2 of an 8-beat packet, num=0 -> packet finishes with TLAST on beat 7, then IDLE.
- S_AXI_ARESETN asserted mid-packet -> TVALID=0 and counters=0 asynchronously. rst_cntrs asserted in the same cycle as a last-beat handshake -> counters read 0.
